// File: rtl/wb_port_arbiter_if.sv
// rtl/wb_port_arbiter_if.sv - writeback/MDU/register-file port bundle for wb_port_arbiter
interface wb_port_arbiter_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
);
    localparam int CW = $clog2(DEPTH + 1);

    // Writeback stage request
    logic            pipe_we_i;
    logic [4:0]      pipe_rd_i;
    logic [XLEN-1:0] pipe_wd_i;

    // MDU result handshake
    logic            mdu_valid_i;
    logic            mdu_ready_o;
    logic [4:0]      mdu_rd_i;
    logic [XLEN-1:0] mdu_wd_i;

    // Register-file write port and status
    logic            rf_we_o;
    logic [4:0]      rf_rd_o;
    logic [XLEN-1:0] rf_wd_o;
    logic            stall_o;
    logic [CW-1:0]   fifo_count_o;

    // Arbiter side
    modport slave (
        input  pipe_we_i, pipe_rd_i, pipe_wd_i,
        input  mdu_valid_i, mdu_rd_i, mdu_wd_i,
        output mdu_ready_o,
        output rf_we_o, rf_rd_o, rf_wd_o,
        output stall_o, fifo_count_o
    );

    // Writeback stage / MDU / register-file side
    modport master (
        output pipe_we_i, pipe_rd_i, pipe_wd_i,
        output mdu_valid_i, mdu_rd_i, mdu_wd_i,
        input  mdu_ready_o,
        input  rf_we_o, rf_rd_o, rf_wd_o,
        input  stall_o, fifo_count_o
    );
endinterface

// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter (pipeline priority, buffered MDU, starvation stall); optional WB_MDU_BYPASS_EN
module wb_port_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic               clk,
    input  logic               rst,
    wb_port_arbiter_if.slave   bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // FIFO storage and pointers
    logic [4:0]      rd_mem_q [DEPTH];
    logic [4:0]      rd_mem_d [DEPTH];
    logic [XLEN-1:0] wd_mem_q [DEPTH];
    logic [XLEN-1:0] wd_mem_d [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    // Starvation tracking
    logic [SW-1:0]   starve_q, starve_d;
    logic            stall_q, stall_d;

    // Grant results
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wd;
    logic            pop;
    logic            push;
    logic            bypass_take;

    logic            pipe_req;
    logic            fifo_empty;
    logic            mdu_ready;
    logic [4:0]      head_rd;
    logic [XLEN-1:0] head_wd;

    // A write to x0 is not a real request and leaves the port to the FIFO
    assign pipe_req   = bus.pipe_we_i && (bus.pipe_rd_i != 5'd0);
    assign fifo_empty = (count_q == '0);
    assign mdu_ready  = (count_q < CW'(DEPTH));
    assign head_rd    = rd_mem_q[rd_ptr_q];
    assign head_wd    = wd_mem_q[rd_ptr_q];

    // Port grant: stalled drain, then pipeline, then FIFO head (then MDU bypass)
    always_comb begin
        rf_we       = 1'b0;
        rf_rd       = '0;
        rf_wd       = '0;
        pop         = 1'b0;
        bypass_take = 1'b0;
        if (stall_q && !fifo_empty) begin
            pop = 1'b1;
            if (head_rd != 5'd0) begin
                rf_we = 1'b1;
                rf_rd = head_rd;
                rf_wd = head_wd;
            end
        end else if (pipe_req) begin
            rf_we = 1'b1;
            rf_rd = bus.pipe_rd_i;
            rf_wd = bus.pipe_wd_i;
        end else if (!fifo_empty) begin
            // An x0 head is discarded silently so it cannot block the queue
            pop = 1'b1;
            if (head_rd != 5'd0) begin
                rf_we = 1'b1;
                rf_rd = head_rd;
                rf_wd = head_wd;
            end
`ifdef WB_MDU_BYPASS_EN
        end else if (!stall_q && bus.mdu_valid_i && (bus.mdu_rd_i != 5'd0)) begin
            // Empty FIFO and idle port: consume the MDU result directly
            bypass_take = 1'b1;
            rf_we       = 1'b1;
            rf_rd       = bus.mdu_rd_i;
            rf_wd       = bus.mdu_wd_i;
`endif
        end
    end

    assign push = bus.mdu_valid_i && mdu_ready && !bypass_take;

    // FIFO next state: storage write, pointer wrap, occupancy
    always_comb begin
        rd_mem_d = rd_mem_q;
        wd_mem_d = wd_mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            rd_mem_d[wr_ptr_q] = bus.mdu_rd_i;
            wd_mem_d[wr_ptr_q] = bus.mdu_wd_i;
            wr_ptr_d           = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Starvation counter: count denied cycles, stall once the limit is reached
    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || pop) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
        stall_d = (starve_d == SW'(STARVE_LIMIT));
    end

    // State registers; reset discards any buffered results
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                rd_mem_q[i] <= '0;
                wd_mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            rd_mem_q <= rd_mem_d;
            wd_mem_q <= wd_mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Write port is forced quiet for as long as reset is held
    assign bus.rf_we_o      = !rst && rf_we;
    assign bus.rf_rd_o      = rst ? 5'd0 : rf_rd;
    assign bus.rf_wd_o      = rst ? '0 : rf_wd;
    assign bus.stall_o      = stall_q;
    assign bus.mdu_ready_o  = mdu_ready;
    assign bus.fifo_count_o = count_q;
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between two requesters:
  - the in-order pipeline Writeback stage (ResultW / RegWriteW / RdW);
  - a long-latency multiply/divide unit (MDU) that completes out of band.
- MDU results are buffered in a small FIFO.
- The pipeline has priority. A starvation counter forces a one-cycle pipeline stall so buffered MDU results always drain.
- Sits between the Writeback stage / MDU and the register file write port.

Parameters:
- DEPTH, 2, MDU result FIFO entries (power of two, >=2).
- STARVE_LIMIT, 4, consecutive cycles a non-empty FIFO may be denied before stall_o asserts (>=1).
- XLEN, 32, data width.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- pipe_we_i  input  1  Writeback stage write request (RegWriteW).
- pipe_rd_i  input  5  Writeback destination register.
- pipe_wd_i  input  XLEN  Writeback data (ResultW).
- mdu_valid_i  input  1  MDU result valid.
- mdu_ready_o  output  1  FIFO can accept an MDU result.
- mdu_rd_i  input  5  MDU destination register.
- mdu_wd_i  input  XLEN  MDU result data.
- rf_we_o  output  1  register-file write enable.
- rf_rd_o  output  5  register-file write address.
- rf_wd_o  output  XLEN  register-file write data.
- stall_o  output  1  hold the Writeback stage this cycle.
- fifo_count_o  output  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset: asynchronous, active-high.
  - FIFO pointers and count, and the starvation counter, go to 0.
  - stall_o=0, fifo_count_o=0, mdu_ready_o=1.
  - rf_we_o/rf_rd_o/rf_wd_o=0 while rst is high, regardless of pipe_we_i.
  - Reset mid-operation discards buffered results (the MDU is reset by the same rst).
- FIFO push:
  - mdu_ready_o = (count < DEPTH), from registered count only; no combinational path from the pop side.
  - Push occurs on mdu_valid_i && mdu_ready_o at the clock edge.
  - When full, the MDU must hold valid/rd/wd stable.
- Effective pipeline request: pipe_req = pipe_we_i && pipe_rd_i != 0. A write to x0 is dropped and leaves the port free.
- Grant, combinational, evaluated each cycle in this order:
  1. stall_o=1 and FIFO non-empty: FIFO head writes; pipeline is not written.
  2. Else if pipe_req: pipeline writes (rf_rd_o=pipe_rd_i, rf_wd_o=pipe_wd_i).
  3. Else if FIFO non-empty and head rd != 0: head writes.
  4. Else: rf_we_o=0, rf_rd_o=0, rf_wd_o=0.
- Pop:
  - The head is popped at the edge whenever it is granted.
  - A head with rd=0 is popped without a write on any cycle it is not denied by pipe_req.
  - Push and pop in the same cycle leave the count unchanged, with correct wrap-around of both pointers.
- Starvation counter:
  - Increments (saturating at STARVE_LIMIT) each cycle the FIFO is non-empty and the head is not popped.
  - Clears on any pop and when the FIFO is empty.
  - stall_o = registered (counter == STARVE_LIMIT), so it asserts exactly one cycle after the limit-th denied cycle.
  - While stall_o=1, the Writeback stage must hold its inputs; the held write is granted on the following cycle (counter cleared by the pop).
- Ordering: write-after-write hazards between the MDU and younger pipeline instructions to the same rd are prevented by issue logic. This block does not compare addresses.
- Latency:
  - Pipeline: 0 cycles (same-cycle write).
  - MDU: >=1 cycle from accept to write.

Optional Feature:
- Macro WB_MDU_BYPASS_EN.
- Defined: when the FIFO is empty, stall_o=0, pipe_req=0 and mdu_valid_i=1 with mdu_rd_i != 0, the MDU result is written in the same cycle (rf_we_o=1, rf_rd_o=mdu_rd_i, rf_wd_o=mdu_wd_i). It is consumed without being pushed, so MDU latency is 0 in this case.
- Undefined: no bypass; every MDU result passes through the FIFO (min latency 1).

Test Plan:
- Reset: assert rst with pipe_we_i=1 -> rf_we_o=0, stall_o=0, mdu_ready_o=1, fifo_count_o=0. Deassert -> pipe_rd_i=5, pipe_wd_i=0xDEADBEEF gives same-cycle rf_we_o=1, rf_rd_o=5, rf_wd_o=0xDEADBEEF.
- Idle drain: push MDU rd=7, wd=0x1234 while pipe_we_i=0 -> next cycle rf_we_o=1, rf_rd_o=7, rf_wd_o=0x1234, then fifo_count_o=0. With WB_MDU_BYPASS_EN the write occurs in the push cycle and fifo_count_o stays 0.
- Full: pipe_we_i=1 continuously, rd=3; push 3 MDU results -> first 2 accepted, mdu_ready_o=0 with fifo_count_o=2, third held until a pop.
- Starvation: FIFO holds 1 entry, pipe_we_i=1 every cycle -> stall_o=1 after 4 denied cycles (STARVE_LIMIT=4). The stall cycle writes the FIFO head. Next cycle stall_o=0 and the held pipeline write completes.
- x0: pipe_rd_i=0 with FIFO head rd=9 -> same cycle rf_rd_o=9, head popped, no x0 write ever asserted.
- Reset mid-operation: FIFO count=2, stall_o=1, assert rst asynchronously between edges -> immediately fifo_count_o=0, stall_o=0, rf_we_o=0.
